// File: rtl/mux_rr_stream_nx1_if.sv
// Stream bundle for the N-to-1 multiplexer: N producer channels in, one consumer out.
interface mux_rr_stream_nx1_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;

  // Multiplexer side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  // Environment side: producers and consumer
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_rr_stream_nx1.sv
// N-channel registered stream multiplexer with round-robin, fixed-priority or manual
// channel selection. Winning channel's beat goes into one output register tagged with its index.
module mux_rr_stream_nx1 #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [SW-1:0]     sel,
  mux_rr_stream_nx1_if.slave bus
);

  typedef enum logic [1:0] {
    ModeRr     = 2'b00,
    ModeFixed  = 2'b01,
    ModeManual = 2'b10,
    ModeRrAlt  = 2'b11
  } mode_e;

  logic [N-1:0]  grant;
  logic          grant_any;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic          load;
  logic          xfer;
  logic          rr_mode;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

  // Grant vector: at most one bit set, chosen according to the current mode
  always_comb begin
    grant = '0;
    unique case (mode_e'(mode))
      ModeFixed: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (grant == '0 && bus.in_valid[k]) grant[k] = 1'b1;
        end
      end
      ModeManual: begin
        // sel values >= N match no channel, so they yield no grant
        for (int unsigned k = 0; k < N; k++) begin
          if (sel == SW'(k)) grant[k] = bus.in_valid[k];
        end
      end
      ModeRr, ModeRrAlt: begin
        // Search rr_ptr..N-1 first, then wrap to 0..rr_ptr-1
        for (int unsigned k = 0; k < N; k++) begin
          if (grant == '0 && bus.in_valid[k] && SW'(k) >= rr_ptr_q) grant[k] = 1'b1;
        end
        for (int unsigned k = 0; k < N; k++) begin
          if (grant == '0 && bus.in_valid[k] && SW'(k) < rr_ptr_q) grant[k] = 1'b1;
        end
      end
    endcase
  end

  // Encode the one-hot grant into an index and select that channel's data
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant[k]) begin
        grant_idx  = SW'(k);
        grant_data = bus.in_data[k*W +: W];
      end
    end
  end

  assign grant_any    = |grant;
  assign rr_mode      = (mode == ModeRr) || (mode == ModeRrAlt);
  assign load         = !out_valid_q || bus.out_ready;
  assign xfer         = load && grant_any;
  // Gated by rst_n so producers see no ready while reset is asserted
  assign bus.in_ready = (rst_n && load) ? grant : '0;

  // Next-state for the output register and the round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      if (rr_mode) begin
        rr_ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held beat immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_stream_nx1.sv
// Bench for mux_rr_stream_nx1: an N=4 instance for most scenarios and an N=3 instance
// for manual out-of-range select, checked against a queue-free behavioural model.
module tb_mux_rr_stream_nx1;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] mode4, mode3;
  logic [1:0] sel4, sel3;

  always #5 clk = ~clk;

  mux_rr_stream_nx1_if #(.N(4), .W(8)) bus4 ();
  mux_rr_stream_nx1_if #(.N(3), .W(8)) bus3 ();

  mux_rr_stream_nx1 #(.N(4), .W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode4),
    .sel   (sel4),
    .bus   (bus4)
  );

  mux_rr_stream_nx1 #(.N(3), .W(8)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode3),
    .sel   (sel3),
    .bus   (bus3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state per instance (index 0: N=4, index 1: N=3)
  logic       m_v[2];
  logic [7:0] m_d[2];
  int         m_ch[2];
  int         m_ptr[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel the rules pick this cycle, or -1 if none
  function automatic int pick(input logic [1:0] m, input int s, input logic [3:0] v,
                              input int ptr, input int n);
    if (m == 2'b01) begin
      for (int k = 0; k < n; k++) if (v[k]) return k;
      return -1;
    end
    if (m == 2'b10) return (s < n && v[s]) ? s : -1;
    for (int off = 0; off < n; off++) if (v[(ptr + off) % n]) return (ptr + off) % n;
    return -1;
  endfunction

  task automatic cmp_model(input int d, input int n, input logic [1:0] m, input int s,
                           input logic [3:0] v, input logic ordy, input logic av,
                           input logic [7:0] ad, input int ach, input logic [3:0] ardy);
    int g;
    logic [3:0] er;
    g  = pick(m, s, v, m_ptr[d], n);
    er = (rst_n === 1'b1 && (!m_v[d] || ordy) && g >= 0) ? 4'(1 << g) : 4'b0;
    chk($sformatf("n%0d out_valid", n), 32'(av), 32'(m_v[d]));
    chk($sformatf("n%0d out_data", n), 32'(ad), 32'(m_d[d]));
    chk($sformatf("n%0d out_ch", n), 32'(ach), 32'(m_ch[d]));
    chk($sformatf("n%0d in_ready", n), 32'(ardy), 32'(er));
  endtask

  task automatic upd_model(input int d, input int n, input logic [1:0] m, input int s,
                           input logic [3:0] v, input logic [31:0] data, input logic ordy);
    int g;
    g = pick(m, s, v, m_ptr[d], n);
    if ((!m_v[d] || ordy) && g >= 0) begin
      m_v[d]  = 1'b1;
      m_d[d]  = data[8*g +: 8];
      m_ch[d] = g;
      if (m != 2'b01 && m != 2'b10) m_ptr[d] = (g + 1) % n;
    end else if (ordy) begin
      m_v[d] = 1'b0;
    end
  endtask

  // Model advance on each clock, reset asynchronously
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_v[d] = 1'b0; m_d[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0;
      end
    end else begin
      upd_model(0, 4, mode4, int'(sel4), bus4.in_valid, bus4.in_data, bus4.out_ready);
      upd_model(1, 3, mode3, int'(sel3), {1'b0, bus3.in_valid}, {8'h00, bus3.in_data},
                bus3.out_ready);
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    cmp_model(0, 4, mode4, int'(sel4), bus4.in_valid, bus4.out_ready, bus4.out_valid,
              bus4.out_data, int'(bus4.out_ch), bus4.in_ready);
    cmp_model(1, 3, mode3, int'(sel3), {1'b0, bus3.in_valid}, bus3.out_ready, bus3.out_valid,
              bus3.out_data, int'(bus3.out_ch), {1'b0, bus3.in_ready});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         rr_seq[6]  = '{0, 1, 2, 3, 0, 1};
  int         sw_ch[3]   = '{3, 1, 3};
  logic [7:0] sw_dat[3]  = '{8'hA3, 8'hA1, 8'hA3};
  logic [3:0] sw_rdy[3]  = '{4'b1000, 4'b0010, 4'b1000};

  initial begin
    rst_n = 1'b0;
    mode4 = 2'b00; sel4 = 2'd0; mode3 = 2'b00; sel3 = 2'd0;
    bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", 32'(bus4.out_valid), 32'd0);
    chk("reset out_ch", 32'(bus4.out_ch), 32'd0);
    chk("reset out_data", 32'(bus4.out_data), 32'd0);

    // Round-robin fairness with all channels requesting
    bus4.in_data  = 32'h13121110;
    bus4.in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr out_ch", 32'(bus4.out_ch), 32'(rr_seq[i]));
      chk("rr out_data", 32'(bus4.out_data), 32'h10 + 32'(rr_seq[i]));
      chk("rr out_valid", 32'(bus4.out_valid), 32'd1);
    end

    // Skip and wrap: only ch1/ch3 valid, pointer now at 2
    bus4.in_valid = 4'b1010;
    bus4.in_data  = 32'hA300A100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("skip in_ready", 32'(bus4.in_ready), 32'(sw_rdy[i]));
      step();
      chk("skip out_ch", 32'(bus4.out_ch), 32'(sw_ch[i]));
      chk("skip out_data", 32'(bus4.out_data), 32'(sw_dat[i]));
    end

    // Fixed priority: ch1 wins every cycle, ch3 starves
    mode4 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fixed in_ready", 32'(bus4.in_ready), 32'b0010);
      step();
      chk("fixed out_ch", 32'(bus4.out_ch), 32'd1);
      chk("fixed out_data", 32'(bus4.out_data), 32'hA1);
    end

    // Backpressure holds the beat and blocks every channel
    mode4 = 2'b00;
    bus4.in_valid  = 4'hF;
    bus4.in_data   = 32'h13121110;
    bus4.out_ready = 1'b0;
    #1;
    chk("bp in_ready", 32'(bus4.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp out_valid", 32'(bus4.out_valid), 32'd1);
      chk("bp out_ch", 32'(bus4.out_ch), 32'd1);
      chk("bp out_data", 32'(bus4.out_data), 32'hA1);
      chk("bp in_ready", 32'(bus4.in_ready), 32'd0);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus4.in_ready), 32'b0001);
    step();
    chk("bp release out_ch", 32'(bus4.out_ch), 32'd0);
    chk("bp release out_data", 32'(bus4.out_data), 32'h10);
    chk("bp release out_valid", 32'(bus4.out_valid), 32'd1);

    // Mode 11 behaves as round-robin (pointer at 1)
    mode4 = 2'b11;
    step();
    chk("mode11 out_ch", 32'(bus4.out_ch), 32'd1);

    // Valid drops: output drains, index holds
    bus4.in_valid = 4'h0;
    step();
    chk("drain out_valid", 32'(bus4.out_valid), 32'd0);
    chk("drain out_ch", 32'(bus4.out_ch), 32'd1);

    // Reset mid-traffic, pointer at 2 before reset
    mode4 = 2'b00;
    bus4.in_valid = 4'hF;
    step();
    chk("pre-reset out_ch", 32'(bus4.out_ch), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(bus4.out_valid), 32'd0);
    chk("async reset out_ch", 32'(bus4.out_ch), 32'd0);
    chk("async reset in_ready", 32'(bus4.in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 32'(bus4.in_ready), 32'b0001);
    step();
    chk("post-reset out_ch", 32'(bus4.out_ch), 32'd0);
    bus4.in_valid = 4'h0;

    // Manual select on N=3, including out-of-range sel
    mode3 = 2'b10;
    sel3  = 2'd2;
    bus3.in_valid = 3'b111;
    bus3.in_data  = 24'h323130;
    #1;
    chk("manual in_ready", 32'(bus3.in_ready), 32'b100);
    step();
    chk("manual out_ch", 32'(bus3.out_ch), 32'd2);
    chk("manual out_data", 32'(bus3.out_data), 32'h32);
    step();
    chk("manual out_valid", 32'(bus3.out_valid), 32'd1);
    sel3 = 2'd3;
    #1;
    chk("oor in_ready", 32'(bus3.in_ready), 32'd0);
    step();
    chk("oor out_valid", 32'(bus3.out_valid), 32'd0);
    chk("oor out_ch", 32'(bus3.out_ch), 32'd2);
    chk("oor out_data", 32'(bus3.out_data), 32'h32);
    sel3 = 2'd0;
    #1;
    chk("manual0 in_ready", 32'(bus3.in_ready), 32'b001);
    step();
    chk("manual0 out_data", 32'(bus3.out_data), 32'h30);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
